// File: rtl/timer_unit.sv
`default_nettype none
// timer_unit -- Game Boy Color DIV/TIMA/TMA/TAC timer (FF04-FF07), T-cycle accurate
// falling-edge tick detection with the delayed TMA reload and interrupt. Rev 1.0
module timer_unit (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       cs_i,
  input  logic       we_i,
  input  logic [1:0] addr_i,
  input  logic [7:0] wdata_i,
  output logic [7:0] rdata_o,
  output logic       irq_o,
  output logic [7:0] div_o
);

  localparam logic [1:0] ADDR_DIV  = 2'd0;
  localparam logic [1:0] ADDR_TIMA = 2'd1;
  localparam logic [1:0] ADDR_TMA  = 2'd2;
  localparam logic [1:0] ADDR_TAC  = 2'd3;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DELAY  = 2'd1;
  localparam logic [1:0] ST_RELOAD = 2'd2;

  localparam logic [1:0] DELAY_CYCLES = 2'd3;

  logic [15:0] sysctr;
  logic [15:0] sysctr_next;
  logic [7:0]  tima;
  logic [7:0]  tima_next;
  logic [7:0]  tma;
  logic [7:0]  tma_next;
  logic [2:0]  tac;
  logic [2:0]  tac_next;
  logic [1:0]  state;
  logic [1:0]  state_next;
  logic [1:0]  dcnt;
  logic [1:0]  dcnt_next;
  logic        tick_prev;
  logic        tick_in;
  logic        tick;
  logic        src_bit;
  logic        wr_en;
  logic        wr_div;
  logic        wr_tima;
  logic        wr_tma;
  logic        wr_tac;

  assign wr_en   = cs_i & we_i;
  assign wr_div  = wr_en & (addr_i == ADDR_DIV);
  assign wr_tima = wr_en & (addr_i == ADDR_TIMA);
  assign wr_tma  = wr_en & (addr_i == ADDR_TMA);
  assign wr_tac  = wr_en & (addr_i == ADDR_TAC);

  // Tick detection looks at the post-write counter and TAC so that a DIV or
  // TAC write pulling the selected bit low produces the hardware's extra tick.
  always_comb begin
    sysctr_next = wr_div ? 16'h0000 : sysctr + 16'd1;
    tac_next    = wr_tac ? wdata_i[2:0] : tac;
    tma_next    = wr_tma ? wdata_i : tma;
  end

  always_comb begin
    src_bit = 1'b0;
    case (tac_next[1:0])
      2'b00:   src_bit = sysctr_next[9];
      2'b01:   src_bit = sysctr_next[3];
      2'b10:   src_bit = sysctr_next[5];
      default: src_bit = sysctr_next[7];
    endcase
  end

  assign tick_in = tac_next[2] & src_bit;
  assign tick    = tick_prev & ~tick_in;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sysctr    <= 16'h0000;
      tac       <= 3'b000;
      tma       <= 8'h00;
      tick_prev <= 1'b0;
    end else begin
      sysctr    <= sysctr_next;
      tac       <= tac_next;
      tma       <= tma_next;
      tick_prev <= tick_in;
    end
  end

  // State register (TIMA lives here since every state decides its next value)
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= ST_RUN;
      dcnt  <= 2'd0;
      tima  <= 8'h00;
    end else begin
      state <= state_next;
      dcnt  <= dcnt_next;
      tima  <= tima_next;
    end
  end

  always_comb begin
    state_next = state;
    dcnt_next  = dcnt;
    tima_next  = tima;
    case (state)
      ST_RUN: begin
        if (wr_tima) begin
          tima_next = wdata_i;
        end else if (tick) begin
          if (tima == 8'hFF) begin
            tima_next  = 8'h00;
            state_next = ST_DELAY;
            dcnt_next  = DELAY_CYCLES;
          end else begin
            tima_next = tima + 8'd1;
          end
        end
      end
      ST_DELAY: begin
        if (wr_tima) begin
          tima_next  = wdata_i;
          state_next = ST_RUN;
          dcnt_next  = 2'd0;
        end else if (dcnt == 2'd0) begin
          tima_next  = tma_next;
          state_next = ST_RELOAD;
        end else begin
          dcnt_next = dcnt - 2'd1;
        end
      end
      ST_RELOAD: begin
        // TIMA keeps tracking TMA for this cycle so a late TMA write lands in TIMA.
        tima_next  = tma_next;
        state_next = ST_RUN;
      end
      default: begin
        state_next = ST_RUN;
        dcnt_next  = 2'd0;
      end
    endcase
  end

  always_comb begin
    irq_o = (state == ST_RELOAD);
    div_o = sysctr[15:8];
    case (addr_i)
      ADDR_DIV:  rdata_o = sysctr[15:8];
      ADDR_TIMA: rdata_o = tima;
      ADDR_TMA:  rdata_o = tma;
      default:   rdata_o = {5'b11111, tac};
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_timer_unit.sv
`default_nettype none
// tb_timer_unit -- scoreboard bench for timer_unit: DIV counting and wrap, TIMA
// overflow/reload latency, DELAY abort, RELOAD-cycle writes and spurious edges.
module tb_timer_unit;

  logic       clk_i;
  logic       rst_ni;
  logic       cs_i;
  logic       we_i;
  logic [1:0] addr_i;
  logic [7:0] wdata_i;
  logic [7:0] rdata_o;
  logic       irq_o;
  logic [7:0] div_o;

  timer_unit dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .cs_i    (cs_i),
    .we_i    (we_i),
    .addr_i  (addr_i),
    .wdata_i (wdata_i),
    .rdata_o (rdata_o),
    .irq_o   (irq_o),
    .div_o   (div_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    string      tag;
    logic [7:0] val;
  } sb_item_t;

  sb_item_t sb_q[$];
  int       n_checks = 0;
  int       n_pass   = 0;
  logic [7:0] v;
  logic       irq_q = 1'b0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
  endtask

  task automatic sb_push(input string tag, input logic [7:0] val);
    sb_item_t it;
    it.tag = tag;
    it.val = val;
    sb_q.push_back(it);
  endtask

  task automatic sb_pop_check(input logic [7:0] obs);
    sb_item_t it;
    if (sb_q.size() == 0) begin
      n_checks++;
      $display("FAIL sb_underflow: got %02h with no queued expectation", obs);
    end else begin
      it = sb_q.pop_front();
      check(it.tag, obs, it.val);
    end
  endtask

  task automatic cycle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] d);
    addr_i = a;
    #1;
    d = rdata_o;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    cs_i    = 1'b1;
    we_i    = 1'b1;
    addr_i  = a;
    wdata_i = d;
    @(posedge clk_i);
    #1;
    cs_i = 1'b0;
    we_i = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [1:0] a, input logic [7:0] exp);
    logic [7:0] d;
    sb_push(tag, exp);
    rd(a, d);
    sb_pop_check(d);
  endtask

  task automatic do_reset();
    cs_i    = 1'b0;
    we_i    = 1'b0;
    addr_i  = 2'd0;
    wdata_i = 8'h00;
    rst_ni  = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
  endtask

  // Leaves the counter at 3 with TAC=101, TMA=tma, TIMA=FE; ticks fall at 16, 32, 48...
  task automatic setup_ovf(input logic [7:0] tma);
    do_reset();
    wr(2'd3, 8'h05);
    wr(2'd2, tma);
    wr(2'd1, 8'hFE);
  endtask

  function automatic logic [7:0] ovf_tima(input int c);
    if (c < 16)      return 8'hFE;
    else if (c < 32) return 8'hFF;
    else if (c < 36) return 8'h00;
    else if (c < 48) return 8'hAB;
    else             return 8'hAC;
  endfunction

  always @(negedge clk_i) begin
    if (irq_o) check("irq_consec", {7'b0, irq_q}, 8'h00);
    irq_q = irq_o;
  end

  initial begin
    rst_ni = 1'b0;
    do_reset();

    // Reset values
    rd_check("rst_div", 2'd0, 8'h00);
    rd_check("rst_tima", 2'd1, 8'h00);
    rd_check("rst_tma", 2'd2, 8'h00);
    rd_check("rst_tac", 2'd3, 8'hF8);
    sb_push("rst_irq", 8'h00);
    sb_pop_check({7'b0, irq_o});
    sb_push("rst_div_o", 8'h00);
    sb_pop_check(div_o);

    // DIV counting and 16-bit wrap
    cycle(255);
    rd_check("div_255", 2'd0, 8'h00);
    cycle(1);
    rd_check("div_256", 2'd0, 8'h01);
    sb_push("div_o_256", 8'h01);
    sb_pop_check(div_o);
    cycle(65279);
    rd_check("div_ffff", 2'd0, 8'hFF);
    cycle(1);
    rd_check("div_wrap", 2'd0, 8'h00);
    sb_push("div_o_wrap", 8'h00);
    sb_pop_check(div_o);
    rd_check("tima_disabled", 2'd1, 8'h00);

    // DIV write holds DIV at zero for 256 cycles
    cycle(300);
    wr(2'd0, 8'h5A);
    cycle(255);
    rd_check("divw_255", 2'd0, 8'h00);
    cycle(1);
    rd_check("divw_256", 2'd0, 8'h01);

    // Overflow, 4-cycle zero window, reload and single irq pulse
    setup_ovf(8'hAB);
    for (int c = 4; c <= 50; c++) begin
      sb_push("ovf_tima", ovf_tima(c));
      sb_push("ovf_irq", (c == 36) ? 8'h01 : 8'h00);
    end
    for (int c = 4; c <= 50; c++) begin
      cycle(1);
      rd(2'd1, v);
      sb_pop_check(v);
      sb_pop_check({7'b0, irq_o});
    end

    // TIMA write inside DELAY cancels reload and interrupt
    setup_ovf(8'hAB);
    cycle(28);
    for (int c = 32; c <= 40; c++) begin
      sb_push("abort_tima", (c < 34) ? 8'h00 : 8'h42);
      sb_push("abort_irq", 8'h00);
    end
    for (int c = 32; c <= 40; c++) begin
      if (c == 34) wr(2'd1, 8'h42);
      else cycle(1);
      rd(2'd1, v);
      sb_pop_check(v);
      sb_pop_check({7'b0, irq_o});
    end

    // TMA write in the RELOAD cycle reaches TIMA
    setup_ovf(8'hAB);
    cycle(32);
    for (int c = 36; c <= 39; c++) begin
      sb_push("rl_tma_tima", (c == 36) ? 8'hAB : 8'h77);
      sb_push("rl_tma_irq", (c == 36) ? 8'h01 : 8'h00);
    end
    for (int c = 36; c <= 39; c++) begin
      if (c == 37) wr(2'd2, 8'h77);
      else cycle(1);
      rd(2'd1, v);
      sb_pop_check(v);
      sb_pop_check({7'b0, irq_o});
    end
    rd_check("rl_tma_reg", 2'd2, 8'h77);

    // TIMA write in the RELOAD cycle is ignored
    setup_ovf(8'hAB);
    cycle(32);
    for (int c = 36; c <= 39; c++) begin
      sb_push("rl_tima_tima", 8'hAB);
    end
    for (int c = 36; c <= 39; c++) begin
      if (c == 37) wr(2'd1, 8'h10);
      else cycle(1);
      rd(2'd1, v);
      sb_pop_check(v);
    end

    // Spurious tick from DIV write while the selected bit is high
    do_reset();
    wr(2'd3, 8'h05);
    cycle(7);
    wr(2'd0, 8'h00);
    rd_check("divspur_tima", 2'd1, 8'h01);
    rd_check("divspur_div", 2'd0, 8'h00);
    wr(2'd0, 8'h00);
    rd_check("divlow_tima", 2'd1, 8'h01);
    cycle(16);
    rd_check("div_realign", 2'd1, 8'h02);

    // Spurious tick from disabling the timer while the selected bit is high
    do_reset();
    wr(2'd3, 8'h05);
    cycle(7);
    wr(2'd3, 8'h01);
    rd_check("tacspur_tima", 2'd1, 8'h01);
    rd_check("tacspur_tac", 2'd3, 8'hF9);
    cycle(24);
    rd_check("tac_off_tima", 2'd1, 8'h01);

    // TIMA write coinciding with a tick: write wins
    do_reset();
    wr(2'd3, 8'h05);
    cycle(14);
    wr(2'd1, 8'h30);
    rd_check("wr_vs_tick", 2'd1, 8'h30);
    cycle(16);
    rd_check("after_wr_tick", 2'd1, 8'h31);

    // Reset asserted mid-DELAY
    setup_ovf(8'hAB);
    cycle(30);
    rst_ni = 1'b0;
    #1;
    rd_check("rstd_div", 2'd0, 8'h00);
    rd_check("rstd_tima", 2'd1, 8'h00);
    rd_check("rstd_tma", 2'd2, 8'h00);
    rd_check("rstd_tac", 2'd3, 8'hF8);
    sb_push("rstd_irq", 8'h00);
    sb_pop_check({7'b0, irq_o});
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    for (int i = 0; i < 10; i++) begin
      sb_push("rstd_post_irq", 8'h00);
    end
    for (int i = 0; i < 10; i++) begin
      cycle(1);
      sb_pop_check({7'b0, irq_o});
    end
    rd_check("rstd_post_tima", 2'd1, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
